mips_execute: RTL and testbench
===============================

# mips_execute

Two-stage integer execute unit of the five-stage MIPS32 pipeline.
- **Stage 1** is a purely combinational ALU. It covers add/sub, logic, shifts, set-less-than, LUI and count-leading-ones/zeros, and produces condition flags for the branch unit.
- **Stage 2** holds the architectural HI/LO accumulator and selects the final result (ALU result, HI, LO or multiply low word).
- The pipeline registers between the two stages live in the processor top, not here.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock (only HI/LO use it).
- Reset  in  1  asynchronous, active-high; clears HI and LO.
- A  in  32  stage-1 operand A (Rs).
- B  in  32  stage-1 operand B (Rt or immediate, selected upstream).
- Shamt  in  5  shift amount for immediate shifts.
- Func  in  6  stage-1 operation code (encoding in `exec_pkg`).
- ALUOut  out  32  stage-1 result.
- CLOut  out  32  CLO/CLZ count, 0..32.
- C, Z, O, N  out  1 each  stage-1 flags.
- S2Func  in  6  stage-2 operation code.
- ACCEn  in  1  HI/LO write enable.
- MULOp  in  1  instruction is a HI/LO-class operation.
- ALUIn  in  32  registered stage-1 result.
- MULIn  in  64  product, or {32'b0, Rs} for MTHI/MTLO, or the count for CLO/CLZ.
- Out  out  32  stage-2 result.

## Operation
Stage 1 operations and results:
- ADD/ADDU: A+B.
- SUB/SUBU: A−B, computed as A+~B+1.
- AND/OR/XOR/NOR: bitwise logic.
- SLT: 1 if A<B signed, else 0.
- SLTU: 1 if A<B unsigned, else 0.
- SLL/SRL/SRA: B shifted by Shamt.
- SLLV/SRLV/SRAV: B shifted by A[4:0].
- LUI: {B[15:0], 16'b0}.
- MOVZ/MOVN: ALUOut = A. The write condition is evaluated outside this block.
- CLO/CLZ:
  - CLOut = number of leading 1s (CLO) or leading 0s (CLZ) of A.
  - All-ones under CLO gives 32; zero under CLZ gives 32.
  - ALUOut = 0.
- Any other code: ALUOut = 0.

Stage 1 flags:
- Z = (ALUOut==0); N = ALUOut[31].
- C = carry out of bit 31 of the 33-bit adder, for ADD/ADDU/SUB/SUBU/SLT/SLTU.
- O = signed overflow of the adder, for the same codes.
- For all other codes, C = O = 0.
- Flags are produced for ADDU/SUBU too; trapping is not implemented.

Stage 2 HI/LO updates, applied when ACCEn & MULOp:
- MULT/MULTU: {HI,LO} ← MULIn.
- MADD/MADDU: {HI,LO} ← {HI,LO} + MULIn.
- MSUB/MSUBU: {HI,LO} ← {HI,LO} − MULIn.
- MTHI: HI ← MULIn[31:0].
- MTLO: LO ← MULIn[31:0].
- All 64-bit arithmetic wraps modulo 2^64.

Stage 2 output selection:
- MFHI: Out = HI.
- MFLO: Out = LO.
- MUL: Out = MULIn[31:0]; HI/LO are not written.
- CLO/CLZ: Out = MULIn[31:0].
- Otherwise: Out = ALUIn.

Boundary rules:
- ACCEn = 0 (a flushed instruction) never changes HI/LO, whatever S2Func is.
- MFHI/MFLO return the pre-edge HI/LO even in a cycle where a write is also requested.

## Timing
- Stage 1: zero latency, no state.
- Stage 2:
  - Out is combinational from the current HI/LO and the inputs.
  - HI/LO update on the rising edge of Clock.
  - A following MFHI/MFLO sees the new value on the next cycle.
- Reset (asynchronous, any time): HI = LO = 0 immediately, and the write is lost. After reset with ALUIn = 0 and a non-HI/LO code, Out = 0.
- One HI/LO operation per cycle; back-to-back MADD ops accumulate every cycle.

## Structure
- `exec_pkg` holds the 6-bit Func localparams:
  - R-type codes use MIPS funct values: SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07, MOVZ 0A, MOVN 0B, MFHI 10, MTHI 11, MFLO 12, MTLO 13, MULT 18, MULTU 19, ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B.
  - Extra codes: LUI 0F, MUL 1A, MADD 1C, MADDU 1D, MSUB 1E, MSUBU 1F, CLZ 30, CLO 31.
- One natural sub-module is `hilo_acc`, containing the stage-2 HI/LO registers and the Out mux. Stage 1 stays inline.

## Test plan
- A=0x7FFFFFFF, B=1, ADD: ALUOut=0x80000000, O=1, N=1, C=0, Z=0.
- A=5, B=5, SUB: ALUOut=0, Z=1, C=1. Then A=1, B=2, SLT: 1; SLTU with A=0xFFFFFFFF, B=1: 0.
- B=0x80000000, Shamt=4: SRA gives 0xF8000000, SRL gives 0x08000000. SLLV with A=33, B=1 shifts by 1: 0x2.
- CLZ with A=0 gives 32; CLZ with A=0x00010000 gives 15; CLO with A=0xF0000000 gives 4.
- Stage 2 accumulator sequence:
  - MULT with MULIn=0x1_00000002 and ACCEn=1; next cycle MFHI=1, MFLO=2.
  - MADD with MULIn=0xFFFFFFFF; then MFHI=2, MFLO=1.
  - MSUB with the same MULIn restores HI=1, LO=2.
- Control and reset:
  - MTLO with ACCEn=0 leaves LO unchanged.
  - Asserting Reset mid-sequence makes MFHI = MFLO = 0 immediately.

Source files
------------

// File: rtl/exec_pkg.sv
// Function codes and helpers shared by the MIPS32 execute unit.
// Stage-1 and stage-2 decoders both key off these 6-bit values.
package exec_pkg;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MOVZ  = 6'h0A;
    localparam logic [5:0] F_MOVN  = 6'h0B;
    localparam logic [5:0] F_LUI   = 6'h0F;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_MUL   = 6'h1A;
    localparam logic [5:0] F_MADD  = 6'h1C;
    localparam logic [5:0] F_MADDU = 6'h1D;
    localparam logic [5:0] F_MSUB  = 6'h1E;
    localparam logic [5:0] F_MSUBU = 6'h1F;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;
    localparam logic [5:0] F_CLZ   = 6'h30;
    localparam logic [5:0] F_CLO   = 6'h31;

    // Leading-ones count; CLZ reuses it on the inverted operand.
    function automatic logic [5:0] clo32(input logic [31:0] v);
        logic       done;
        logic [5:0] cnt;
        done = 1'b0;
        cnt  = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) cnt = cnt + 6'd1;
                else      done = 1'b1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mips_execute_if.sv
// Operand/result bundle of the execute unit.
// master drives operands and control, slave returns results.
interface mips_execute_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic [5:0]  Func;
    logic [31:0] ALUOut;
    logic [31:0] CLOut;
    logic        C;
    logic        Z;
    logic        O;
    logic        N;
    logic [5:0]  S2Func;
    logic        ACCEn;
    logic        MULOp;
    logic [31:0] ALUIn;
    logic [63:0] MULIn;
    logic [31:0] Out;

    modport master (
        output A, B, Shamt, Func,
        output S2Func, ACCEn, MULOp, ALUIn, MULIn,
        input  ALUOut, CLOut, C, Z, O, N, Out
    );

    modport slave (
        input  A, B, Shamt, Func,
        input  S2Func, ACCEn, MULOp, ALUIn, MULIn,
        output ALUOut, CLOut, C, Z, O, N, Out
    );
endinterface

// File: rtl/mips_execute_hilo_acc.sv
// Stage 2: architectural HI/LO accumulator and final result mux.
// Out reads pre-edge HI/LO, so MFHI/MFLO never see a same-cycle write.
module hilo_acc
    import exec_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_func,
    input  logic        i_acc_en,
    input  logic        i_mul_op,
    input  logic [31:0] i_alu_in,
    input  logic [63:0] i_mul_in,
    output logic [31:0] o_out
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_wr;
    logic [63:0] w_acc;
    logic [63:0] w_sum;
    logic [63:0] w_dif;
    logic        w_mfhi;
    logic        w_mflo;
    logic        w_pass;

    assign w_wr  = i_acc_en & i_mul_op;
    assign w_acc = {r_hi, r_lo};
    assign w_sum = w_acc + i_mul_in;
    assign w_dif = w_acc - i_mul_in;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_wr) begin
            case (i_func)
                F_MULT, F_MULTU: begin
                    r_hi <= i_mul_in[63:32];
                    r_lo <= i_mul_in[31:0];
                end
                F_MADD, F_MADDU: begin
                    r_hi <= w_sum[63:32];
                    r_lo <= w_sum[31:0];
                end
                F_MSUB, F_MSUBU: begin
                    r_hi <= w_dif[63:32];
                    r_lo <= w_dif[31:0];
                end
                F_MTHI: r_hi <= i_mul_in[31:0];
                F_MTLO: r_lo <= i_mul_in[31:0];
                default: ;
            endcase
        end
    end

    assign w_mfhi = (i_func == F_MFHI);
    assign w_mflo = (i_func == F_MFLO);
    assign w_pass = (i_func == F_MUL) | (i_func == F_CLO)
                  | (i_func == F_CLZ);

    always_comb begin
        o_out = i_alu_in;
        unique case (1'b1)
            w_mfhi:  o_out = r_hi;
            w_mflo:  o_out = r_lo;
            w_pass:  o_out = i_mul_in[31:0];
            default: o_out = i_alu_in;
        endcase
    end

endmodule

// File: rtl/mips_execute.sv
// Two-stage MIPS32 integer execute unit: combinational ALU (stage 1)
// and HI/LO accumulator with result select (stage 2).
module mips_execute
    import exec_pkg::*;
(
    input  logic    Clock,
    input  logic    Reset,
    mips_execute_if.slave bus
);

    logic        w_sub;
    logic        w_arith;
    logic [31:0] w_bop;
    logic [32:0] w_sum;
    logic        w_ovf;
    logic        w_lt_s;
    logic        w_lt_u;
    logic [31:0] w_alu;
    logic [31:0] w_b;
    logic [31:0] w_a;
    logic [4:0]  w_vsh;
    logic [5:0]  w_cl;
    logic        w_is_cl;

    assign w_a   = bus.A;
    assign w_b   = bus.B;
    assign w_vsh = bus.A[4:0];

    assign w_sub = (bus.Func == F_SUB)  | (bus.Func == F_SUBU)
                 | (bus.Func == F_SLT)  | (bus.Func == F_SLTU);
    assign w_arith = w_sub | (bus.Func == F_ADD)
                   | (bus.Func == F_ADDU);

    // Shared 33-bit adder: subtraction is A + ~B + 1.
    assign w_bop = w_sub ? ~w_b : w_b;
    assign w_sum = {1'b0, w_a} + {1'b0, w_bop} + {32'd0, w_sub};
    assign w_ovf = (w_a[31] == w_bop[31]) & (w_sum[31] != w_a[31]);
    assign w_lt_s = w_sum[31] ^ w_ovf;
    assign w_lt_u = ~w_sum[32];

    assign w_is_cl = (bus.Func == F_CLO) | (bus.Func == F_CLZ);
    assign w_cl = clo32((bus.Func == F_CLZ) ? ~w_a : w_a);

    always_comb begin
        w_alu = 32'd0;
        case (bus.Func)
            F_ADD, F_ADDU,
            F_SUB, F_SUBU: w_alu = w_sum[31:0];
            F_AND:  w_alu = w_a & w_b;
            F_OR:   w_alu = w_a | w_b;
            F_XOR:  w_alu = w_a ^ w_b;
            F_NOR:  w_alu = ~(w_a | w_b);
            F_SLT:  w_alu = {31'd0, w_lt_s};
            F_SLTU: w_alu = {31'd0, w_lt_u};
            F_SLL:  w_alu = w_b << bus.Shamt;
            F_SRL:  w_alu = w_b >> bus.Shamt;
            F_SRA:  w_alu = $signed(w_b) >>> bus.Shamt;
            F_SLLV: w_alu = w_b << w_vsh;
            F_SRLV: w_alu = w_b >> w_vsh;
            F_SRAV: w_alu = $signed(w_b) >>> w_vsh;
            F_LUI:  w_alu = {w_b[15:0], 16'd0};
            F_MOVZ, F_MOVN: w_alu = w_a;
            default: w_alu = 32'd0;
        endcase
    end

    assign bus.ALUOut = w_alu;
    assign bus.CLOut  = w_is_cl ? {26'd0, w_cl} : 32'd0;
    assign bus.Z      = (w_alu == 32'd0);
    assign bus.N      = w_alu[31];
    assign bus.C      = w_arith & w_sum[32];
    assign bus.O      = w_arith & w_ovf;

    hilo_acc u_hilo (
        .i_clk    (Clock),
        .i_rst    (Reset),
        .i_func   (bus.S2Func),
        .i_acc_en (bus.ACCEn),
        .i_mul_op (bus.MULOp),
        .i_alu_in (bus.ALUIn),
        .i_mul_in (bus.MULIn),
        .o_out    (bus.Out)
    );

endmodule

// File: tb/tb_mips_execute.sv
// Directed self-checking bench for mips_execute.
// Expected values are hand-computed constants.
module tb_mips_execute;
    import exec_pkg::*;

    logic Clock;
    logic Reset;
    int   n_chk;
    int   n_fail;

    mips_execute_if bus ();

    mips_execute dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic s1(input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh);
        bus.Func  = f;
        bus.A     = a;
        bus.B     = b;
        bus.Shamt = sh;
        #1;
    endtask

    task automatic s2(input logic [5:0] f, input logic en,
                      input logic mop, input logic [63:0] m);
        bus.S2Func = f;
        bus.ACCEn  = en;
        bus.MULOp  = mop;
        bus.MULIn  = m;
        #1;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        Reset  = 1'b1;
        bus.A = '0; bus.B = '0; bus.Shamt = '0; bus.Func = F_ADD;
        bus.S2Func = F_ADD; bus.ACCEn = 1'b0; bus.MULOp = 1'b0;
        bus.ALUIn = '0; bus.MULIn = '0;
        #12;
        check("rst_out", bus.Out, 0);
        s2(F_MFHI, 0, 0, 0);
        check("rst_hi", bus.Out, 0);
        s2(F_MFLO, 0, 0, 0);
        check("rst_lo", bus.Out, 0);
        Reset = 1'b0;

        s1(F_ADD, 32'h7FFFFFFF, 32'h1, 0);
        check("add_res", bus.ALUOut, 64'h80000000);
        check("add_O", bus.O, 1);
        check("add_N", bus.N, 1);
        check("add_C", bus.C, 0);
        check("add_Z", bus.Z, 0);

        s1(F_SUB, 5, 5, 0);
        check("sub_res", bus.ALUOut, 0);
        check("sub_Z", bus.Z, 1);
        check("sub_C", bus.C, 1);
        check("sub_O", bus.O, 0);

        s1(F_SLT, 1, 2, 0);
        check("slt", bus.ALUOut, 1);
        s1(F_SLT, 32'hFFFFFFFF, 1, 0);
        check("slt_neg", bus.ALUOut, 1);
        s1(F_SLTU, 32'hFFFFFFFF, 1, 0);
        check("sltu", bus.ALUOut, 0);

        s1(F_SRA, 0, 32'h80000000, 4);
        check("sra", bus.ALUOut, 64'hF8000000);
        s1(F_SRL, 0, 32'h80000000, 4);
        check("srl", bus.ALUOut, 64'h08000000);
        s1(F_SLLV, 33, 1, 0);
        check("sllv", bus.ALUOut, 2);
        s1(F_SLL, 0, 32'h0000000F, 31);
        check("sll", bus.ALUOut, 64'h80000000);
        check("sll_C", bus.C, 0);
        s1(F_LUI, 0, 32'h1234ABCD, 0);
        check("lui", bus.ALUOut, 64'hABCD0000);
        s1(F_NOR, 32'h0F0F0000, 32'h000000FF, 0);
        check("nor", bus.ALUOut, 64'hF0F0FF00);
        s1(F_MOVN, 32'hDEADBEEF, 0, 0);
        check("movn", bus.ALUOut, 64'hDEADBEEF);
        s1(6'h3F, 32'h1, 32'h1, 0);
        check("undef", bus.ALUOut, 0);
        check("undef_Z", bus.Z, 1);

        s1(F_CLZ, 0, 0, 0);
        check("clz0", bus.CLOut, 32);
        check("clz0_alu", bus.ALUOut, 0);
        s1(F_CLZ, 32'h00010000, 0, 0);
        check("clz15", bus.CLOut, 15);
        s1(F_CLO, 32'hF0000000, 0, 0);
        check("clo4", bus.CLOut, 4);
        s1(F_CLO, 32'hFFFFFFFF, 0, 0);
        check("clo32", bus.CLOut, 32);

        @(negedge Clock);
        s2(F_MULT, 1, 1, 64'h1_00000002);
        tick();
        s2(F_MFHI, 0, 0, 0);
        check("mult_hi", bus.Out, 1);
        s2(F_MFLO, 0, 0, 0);
        check("mult_lo", bus.Out, 2);

        s2(F_MADD, 1, 1, 64'hFFFFFFFF);
        tick();
        s2(F_MFHI, 0, 0, 0);
        check("madd_hi", bus.Out, 2);
        s2(F_MFLO, 0, 0, 0);
        check("madd_lo", bus.Out, 1);

        s2(F_MSUB, 1, 1, 64'hFFFFFFFF);
        tick();
        s2(F_MFHI, 0, 0, 0);
        check("msub_hi", bus.Out, 1);
        s2(F_MFLO, 0, 0, 0);
        check("msub_lo", bus.Out, 2);

        s2(F_MTLO, 0, 1, 64'h55);
        tick();
        s2(F_MFLO, 0, 0, 0);
        check("mtlo_flush", bus.Out, 2);

        s2(F_MULT, 1, 0, 64'h77_00000077);
        tick();
        s2(F_MFHI, 0, 0, 0);
        check("nomulop_hi", bus.Out, 1);

        s2(F_MTLO, 1, 1, 64'h55);
        tick();
        s2(F_MFLO, 0, 0, 0);
        check("mtlo", bus.Out, 64'h55);
        s2(F_MFHI, 0, 0, 0);
        check("mtlo_hi", bus.Out, 1);

        s2(F_MUL, 1, 0, 64'h9_0000ABCD);
        check("mul_out", bus.Out, 64'hABCD);
        tick();
        s2(F_MFHI, 0, 0, 0);
        check("mul_nowr", bus.Out, 1);

        bus.ALUIn = 32'hCAFEF00D;
        s2(F_ADD, 0, 0, 0);
        check("pass_alu", bus.Out, 64'hCAFEF00D);

        s2(F_MADD, 1, 1, 64'h10);
        #2;
        Reset = 1'b1;
        #1;
        s2(F_MFHI, 0, 0, 0);
        check("arst_hi", bus.Out, 0);
        s2(F_MFLO, 0, 0, 0);
        check("arst_lo", bus.Out, 0);
        s2(F_MADD, 1, 1, 64'h10);
        tick();
        s2(F_MFLO, 0, 0, 0);
        check("arst_hold", bus.Out, 0);
        Reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
